uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an elaboration-sized transmit FIFO; frames are sent back-to-back
// while the FIFO holds data. State table: IDLE waiting | START start bit | DATA payload
// LSB first | PARITY optional parity bit | STOP one or two stop bits.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          data_tx,
  input  logic                          valid,
  output logic                          tx_ready,
  output logic                          uart_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (STOP_BITS * DIV > 1) ? $clog2(STOP_BITS * DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_BITS * DIV - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);
  localparam logic          ODD       = (PARITY == 1);

  generate
    if (DIV < 2) begin : g_div_chk
      $error("uart_tx_fifo: baud divisor must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_param_chk
      $error("uart_tx_fifo: unsupported parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 overflow_q;
  logic                 push, pop;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 out_q, out_d;
  logic                 tc, load_frame;

  assign tx_ready   = (count_q != FULL);
  assign push       = valid && tx_ready;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign uart_out   = out_q;
  assign busy       = (count_q != '0) || (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_tx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow_q <= valid && !tx_ready;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      out_q   <= out_d;
    end
  end

  assign tc = (baud_q == '0);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    out_d      = out_q;
    pop        = 1'b0;
    load_frame = 1'b0;
    if (state_q != S_IDLE && !tc) baud_d = baud_q - CW'(1);
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) load_frame = 1'b1;
      end
      S_START: begin
        if (tc) begin
          state_d = S_DATA;
          baud_d  = BIT_LOAD;
          bit_d   = '0;
          out_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (tc) begin
          if (bit_q != BW'(DATA_BITS - 1)) begin
            baud_d  = BIT_LOAD;
            bit_d   = bit_q + BW'(1);
            out_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end else if (PARITY != 0) begin
            state_d = S_PARITY;
            baud_d  = BIT_LOAD;
            out_d   = par_q;
          end else begin
            state_d = S_STOP;
            baud_d  = STOP_LOAD;
            out_d   = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tc) begin
          state_d = S_STOP;
          baud_d  = STOP_LOAD;
          out_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (tc) begin
          if (count_q != '0) begin
            load_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
            out_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = 1'b1;
      end
    endcase
    // Starting a frame pops the head entry and drives the start bit on the same edge.
    if (load_frame) begin
      pop     = 1'b1;
      state_d = S_START;
      baud_d  = BIT_LOAD;
      shift_d = mem_q[rd_ptr_q];
      par_d   = (^mem_q[rd_ptr_q]) ^ ODD;
      out_d   = 1'b0;
    end
  end

endmodule
